// File: rtl/serv_ibus_prefetch.sv
// One-entry next-line instruction prefetcher between the SERV ibus and memory.
// Define SERV_IBUS_PREFETCH_SNOOP_EN to invalidate the buffer on matching dbus writes.
module serv_ibus_prefetch #(
  parameter logic [31:0] STRIDE = 32'd4
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_cpu_adr,
  input  logic        i_cpu_cyc,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  output logic [31:0] o_mem_adr,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack,
  input  logic [31:0] i_snoop_adr,
  input  logic        i_snoop_we,
  input  logic        i_snoop_ack,
  output logic        o_hit
);

  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [29:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;
  logic        ack_q, ack_d;
  logic        hit_q, hit_d;
  logic [31:0] rdt_q, rdt_d;
  logic [31:0] adr_q, adr_d;
  logic        cyc_q, cyc_d;

  logic pend, buf_match, flight_match, mem_ack, snoop_kill, stale_now;

  // The ack cycle still shows the old request, so it must not count as a new one.
  assign pend         = i_cpu_cyc & ~ack_q;
  assign buf_match    = (tag_q == i_cpu_adr[31:2]);
  assign flight_match = (adr_q[31:2] == i_cpu_adr[31:2]);
  assign mem_ack      = i_mem_ack & cyc_q;

`ifdef SERV_IBUS_PREFETCH_SNOOP_EN
  logic stale_q, stale_d;
  logic snoop_wr, snoop_flight;
  assign snoop_wr     = i_snoop_we & i_snoop_ack;
  assign snoop_kill   = snoop_wr & (i_snoop_adr[31:2] == tag_q);
  assign snoop_flight = snoop_wr & (i_snoop_adr[31:2] == adr_q[31:2]) & (state_q == PREFETCH);
  assign stale_now    = stale_q | snoop_flight;
`else
  logic unused_snoop;
  assign unused_snoop = ^{i_snoop_adr, i_snoop_we, i_snoop_ack};
  assign snoop_kill   = 1'b0;
  assign stale_now    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q & ~snoop_kill;
    tag_d   = tag_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    hit_d   = 1'b0;
    rdt_d   = rdt_q;
    adr_d   = adr_q;
    cyc_d   = cyc_q;
`ifdef SERV_IBUS_PREFETCH_SNOOP_EN
    stale_d = stale_now;
`endif
    case (state_q)
      IDLE: if (pend) begin
        if (valid_q & ~snoop_kill & buf_match) begin
          ack_d   = 1'b1;
          hit_d   = 1'b1;
          rdt_d   = data_q;
          valid_d = 1'b0;
          state_d = PREFETCH;
          cyc_d   = 1'b1;
          adr_d   = i_cpu_adr + STRIDE;
        end else begin
          valid_d = 1'b0;
          state_d = DEMAND;
          cyc_d   = 1'b1;
          adr_d   = i_cpu_adr;
        end
      end
      DEMAND: if (mem_ack) begin
        rdt_d   = i_mem_rdt;
        ack_d   = 1'b1;
        state_d = PREFETCH;
        adr_d   = adr_q + STRIDE;
      end
      PREFETCH: if (mem_ack) begin
`ifdef SERV_IBUS_PREFETCH_SNOOP_EN
        stale_d = 1'b0;
`endif
        if (pend & flight_match & ~stale_now) begin
          ack_d = 1'b1;
          hit_d = 1'b1;
          rdt_d = i_mem_rdt;
          adr_d = adr_q + STRIDE;
        end else if (pend) begin
          // In-flight word is useless (wrong address or stale): refetch on demand.
          state_d = DEMAND;
          adr_d   = i_cpu_adr;
        end else begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          if (~stale_now) begin
            valid_d = 1'b1;
            tag_d   = adr_q[31:2];
            data_d  = i_mem_rdt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      hit_q   <= 1'b0;
      rdt_q   <= '0;
      adr_q   <= '0;
      cyc_q   <= 1'b0;
`ifdef SERV_IBUS_PREFETCH_SNOOP_EN
      stale_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      hit_q   <= hit_d;
      rdt_q   <= rdt_d;
      adr_q   <= adr_d;
      cyc_q   <= cyc_d;
`ifdef SERV_IBUS_PREFETCH_SNOOP_EN
      stale_q <= stale_d;
`endif
    end
  end

  assign o_cpu_ack = ack_q;
  assign o_cpu_rdt = rdt_q;
  assign o_hit     = hit_q;
  assign o_mem_adr = adr_q;
  assign o_mem_cyc = cyc_q;

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// Bench for serv_ibus_prefetch: directed scenarios then random fetch streams
// against a sequential-address hit model and a latency-programmable memory.
module tb_serv_ibus_prefetch;

  logic        clk;
  logic        i_rst_n;
  logic [31:0] i_cpu_adr;
  logic        i_cpu_cyc;
  logic [31:0] o_cpu_rdt;
  logic        o_cpu_ack;
  logic [31:0] o_mem_adr;
  logic        o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;
  logic [31:0] i_snoop_adr;
  logic        i_snoop_we;
  logic        i_snoop_ack;
  logic        o_hit;

  serv_ibus_prefetch dut (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_cpu_adr(i_cpu_adr), .i_cpu_cyc(i_cpu_cyc),
    .o_cpu_rdt(o_cpu_rdt), .o_cpu_ack(o_cpu_ack),
    .o_mem_adr(o_mem_adr), .o_mem_cyc(o_mem_cyc),
    .i_mem_rdt(i_mem_rdt), .i_mem_ack(i_mem_ack),
    .i_snoop_adr(i_snoop_adr), .i_snoop_we(i_snoop_we), .i_snoop_ack(i_snoop_ack),
    .o_hit(o_hit)
  );

  always #5 clk = ~clk;

  int tests, fails;
  int unsigned ver [logic [31:0]];
  int mem_lat_fixed, rand_lat, ack_count, unstable;
  int late_req, late_done;
  logic [31:0] at_mem_adr;
  logic        at_mem_cyc;
  int          at_acks;

  function automatic logic [31:0] memval(input logic [31:0] a);
    logic [31:0] v;
    v = ver.exists(a) ? ver[a] : 0;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678 ^ (v << 24);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: acks after eff_lat cycles of o_mem_cyc, one-cycle ack pulses.
  initial begin
    int cnt, eff;
    logic [31:0] adr_seen;
    i_mem_ack = 1'b0; i_mem_rdt = '0; cnt = 0; rand_lat = 1; adr_seen = '0;
    ack_count = 0; unstable = 0; late_done = 0;
    forever begin
      @(posedge clk); #1;
      i_mem_ack = 1'b0;
      eff = (mem_lat_fixed != 0) ? mem_lat_fixed : rand_lat;
      if (late_req != late_done) begin
        late_done = late_req;
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'hDEAD_BEEF;
        cnt = 0;
      end else if (o_mem_cyc) begin
        if (cnt == 0) adr_seen = o_mem_adr;
        else if (o_mem_adr !== adr_seen) unstable++;
        cnt++;
        if (cnt >= eff) begin
          i_mem_ack = 1'b1;
          i_mem_rdt = memval(o_mem_adr);
          cnt = 0;
          rand_lat = $urandom_range(1, 3);
          ack_count++;
        end
      end else cnt = 0;
    end
  end

  // CPU fetch: hold request until ack, check ack cycle, then release.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_hit,
                       input int exp_lat);
    int n, acks0;
    acks0 = ack_count;
    i_cpu_adr = a; i_cpu_cyc = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!o_cpu_ack && n < 40);
    check("ack_seen", o_cpu_ack, 1);
    if (o_cpu_ack) begin
      check("rdt", o_cpu_rdt, exp_d);
      check("hit", o_hit, exp_hit);
      if (exp_lat > 0) check("latency", n, exp_lat);
      at_mem_adr = o_mem_adr;
      at_mem_cyc = o_mem_cyc;
      at_acks    = ack_count - acks0;
    end
    @(posedge clk); #1;
    check("ack_one_cycle", o_cpu_ack, 0);
    check("hit_one_cycle", o_hit, 0);
    i_cpu_cyc = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_mem_cyc && n < 50) begin @(posedge clk); #1; n++; end
    check("idle_timeout", o_mem_cyc, 0);
  endtask

  task automatic snoop(input logic [31:0] a);
    i_snoop_adr = a; i_snoop_we = 1'b1; i_snoop_ack = 1'b1;
    @(posedge clk); #1;
    i_snoop_we = 1'b0; i_snoop_ack = 1'b0;
    ver[a] = (ver.exists(a) ? ver[a] : 0) + 1;
  endtask

  initial begin
    logic [31:0] old_d, a, prev;
    logic prev_ok, exp_hit;
    int exp_lat, r;
    tests = 0; fails = 0; late_req = 0; mem_lat_fixed = 2;
    clk = 1'b0; i_rst_n = 1'b0; i_cpu_adr = '0; i_cpu_cyc = 1'b0;
    i_snoop_adr = '0; i_snoop_we = 1'b0; i_snoop_ack = 1'b0;
    at_mem_adr = '0; at_mem_cyc = 1'b0; at_acks = 0;
    #1;
    check("rst_ack", o_cpu_ack, 0);
    check("rst_rdt", o_cpu_rdt, 0);
    check("rst_mem_cyc", o_mem_cyc, 0);
    check("rst_mem_adr", o_mem_adr, 0);
    check("rst_hit", o_hit, 0);
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss, then sequential hit, then redirect while prefetching
    fetch(32'h100, memval(32'h100), 0, 3);
    check("miss_pf_adr", at_mem_adr, 32'h104);
    check("miss_pf_cyc", at_mem_cyc, 1);
    wait_idle();
    fetch(32'h104, memval(32'h104), 1, 1);
    check("hit_no_mem", at_acks, 0);
    check("hit_pf_adr", at_mem_adr, 32'h108);
    check("hit_pf_cyc", at_mem_cyc, 1);
    fetch(32'h200, memval(32'h200), 0, -1);
    check("redirect_pf_adr", at_mem_adr, 32'h204);
    fetch(32'h204, memval(32'h204), 1, -1);
    check("inflight_pf_adr", at_mem_adr, 32'h208);

    // Address wrap
    wait_idle();
    fetch(32'hFFFF_FFFC, memval(32'hFFFF_FFFC), 0, 3);
    check("wrap_pf_adr", at_mem_adr, 32'h0);
    wait_idle();
    fetch(32'h0, memval(32'h0), 1, 1);
    check("wrap_hit_pf_adr", at_mem_adr, 32'h4);

    // dbus write to the buffered word
    wait_idle();
    fetch(32'h100, memval(32'h100), 0, 3);
    wait_idle();
    old_d = memval(32'h104);
    snoop(32'h104);
`ifdef SERV_IBUS_PREFETCH_SNOOP_EN
    fetch(32'h104, memval(32'h104), 0, 3);
    mem_lat_fixed = 3;
    wait_idle();
    fetch(32'h500, memval(32'h500), 0, 4);
    snoop(32'h504);
    fetch(32'h504, memval(32'h504), 0, -1);
`else
    fetch(32'h104, old_d, 1, 1);
`endif

    // Reset in the middle of a demand fetch, late memory ack afterwards
    mem_lat_fixed = 2;
    wait_idle();
    fetch(32'h2FC, memval(32'h2FC), 0, -1);
    wait_idle();
    mem_lat_fixed = 6;
    i_cpu_adr = 32'h400; i_cpu_cyc = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("demand_cyc", o_mem_cyc, 1);
    check("demand_adr", o_mem_adr, 32'h400);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_cyc", o_mem_cyc, 0);
    check("async_rst_adr", o_mem_adr, 0);
    check("async_rst_ack", o_cpu_ack, 0);
    check("async_rst_rdt", o_cpu_rdt, 0);
    check("async_rst_hit", o_hit, 0);
    i_cpu_cyc = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    late_req++;
    repeat (4) begin
      @(posedge clk); #1;
      check("late_ack_cpu_ack", o_cpu_ack, 0);
      check("late_ack_mem_cyc", o_mem_cyc, 0);
    end
    check("late_ack_rdt", o_cpu_rdt, 0);
    mem_lat_fixed = 2;
    fetch(32'h300, memval(32'h300), 0, 3);

    // Random streams: a request hits exactly when it follows the last one by one word
    wait_idle();
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    mem_lat_fixed = 0;
    prev_ok = 1'b0; prev = '0;
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      r = $urandom_range(0, 9);
      if (r < 6 && prev_ok) a = prev + 32'd4;
      else if (r == 9) a = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;
      else a = 32'h1000 + {$urandom_range(0, 63), 2'b00};
      exp_hit = prev_ok && (a == prev + 32'd4);
      exp_lat = o_mem_cyc ? -1 : (exp_hit ? 1 : rand_lat + 1);
      fetch(a, memval(a), exp_hit, exp_lat);
      prev = a; prev_ok = 1'b1;
    end
    check("mem_adr_stable", unstable, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
